// File: rtl/scm_pkg.sv
// Shared definitions for the sample change monitor.
//   evt_t    : one change record {ts, prev, curr, rose, fell}
//   make_evt : builds a record from two consecutive samples and the edge timestamp
package scm_pkg;

  localparam int SCM_WIDTH = 8;
  localparam int SCM_TS_W  = 16;

  typedef struct packed {
    logic [SCM_TS_W-1:0]  ts;
    logic [SCM_WIDTH-1:0] prev;
    logic [SCM_WIDTH-1:0] curr;
    logic [SCM_WIDTH-1:0] rose;
    logic [SCM_WIDTH-1:0] fell;
  } evt_t;

  // rose/fell follow $rose/$fell per bit: 0->1 and 1->0 between the two samples.
  function automatic evt_t make_evt(input logic [SCM_WIDTH-1:0] prev,
                                    input logic [SCM_WIDTH-1:0] curr,
                                    input logic [SCM_TS_W-1:0]  ts);
    evt_t e;
    e.ts   = ts;
    e.prev = prev;
    e.curr = curr;
    e.rose = curr & ~prev;
    e.fell = ~curr & prev;
    return e;
  endfunction

endpackage

// File: rtl/scm_fifo.sv
// Synchronous FIFO of evt_t records.
//   clk, rst_n : clock, synchronous active-low reset (flushes pointers and count)
//   push, din  : write request and record; accepted when not full, or when a pop
//                happens in the same cycle
//   pop        : removes the head record (ignored when empty)
//   dout       : head record, all zero when empty
//   full, empty, level : derived from the occupancy count
module scm_fifo
  import scm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  evt_t             din,
  input  logic             pop,
  output evt_t             dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  evt_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot the push needs, so full does not block it.
  assign do_push = push && (!full || do_pop);

  // Control: pointers wrap modulo DEPTH (power of two), count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage: no reset needed, the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/sample_change_monitor.sv
// Samples a bus once per enabled clock, turns every change between consecutive
// samples into a record {ts, prev, curr, rose, fell} and delivers the records
// through a small FIFO over valid/ready.
//   clk, rst_n          : clock, synchronous active-low reset
//   en                  : sampling enable (timestamp runs regardless)
//   sig_in              : monitored bus
//   clear_ovf           : clears overflow and drop_cnt
//   evt_ready/evt_valid : record handshake, pop on valid && ready
//   evt_ts/prev/curr/rose/fell : head record, zero when no record is queued
//   overflow, drop_cnt  : sticky drop flag and saturating drop counter
//   level               : FIFO occupancy
// The record layout comes from scm_pkg, so WIDTH and TS_W must match its widths.
module sample_change_monitor
  import scm_pkg::*;
#(
  parameter int WIDTH  = SCM_WIDTH,
  parameter int DEPTH  = 4,
  parameter int TS_W   = SCM_TS_W,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [WIDTH-1:0]       sig_in,
  input  logic                   clear_ovf,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic [TS_W-1:0]        evt_ts,
  output logic [WIDTH-1:0]       evt_prev,
  output logic [WIDTH-1:0]       evt_curr,
  output logic [WIDTH-1:0]       evt_rose,
  output logic [WIDTH-1:0]       evt_fell,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] samp_q;
  logic             primed;
  logic [TS_W-1:0]  ts;

  logic push_req;
  logic pop;
  logic drop;
  logic fifo_full;
  logic fifo_empty;
  evt_t new_evt;
  evt_t head;

  // A change only counts once there is a previous sample to compare against.
  assign push_req = en && primed && (sig_in != samp_q);
  assign pop      = evt_valid && evt_ready;
  assign drop     = push_req && fifo_full && !pop;
  assign new_evt  = make_evt(samp_q, sig_in, ts);

  // Sample stage: the register sees sig_in as it was just before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q <= '0;
      primed <= 1'b0;
      ts     <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (en) begin
        samp_q <= sig_in;
        primed <= 1'b1;
      end
    end
  end

  // Drop accounting: a clear in the same cycle as a drop still counts that drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  scm_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (new_evt),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign evt_valid = !fifo_empty;
  assign evt_ts    = head.ts;
  assign evt_prev  = head.prev;
  assign evt_curr  = head.curr;
  assign evt_rose  = head.rose;
  assign evt_fell  = head.fell;

endmodule

// File: tb/tb_sample_change_monitor.sv
module tb_sample_change_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  sig_in;
  logic        clear_ovf;
  logic        evt_ready;
  logic        evt_valid;
  logic [15:0] evt_ts;
  logic [7:0]  evt_prev;
  logic [7:0]  evt_curr;
  logic [7:0]  evt_rose;
  logic [7:0]  evt_fell;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [2:0]  level;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sample_change_monitor #(
    .WIDTH  (8),
    .DEPTH  (4),
    .TS_W   (16),
    .DROP_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sig_in    (sig_in),
    .clear_ovf (clear_ovf),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_ts    (evt_ts),
    .evt_prev  (evt_prev),
    .evt_curr  (evt_curr),
    .evt_rose  (evt_rose),
    .evt_fell  (evt_fell),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // While a record is presented and not taken, it must stay put.
  assert property (@(posedge clk) disable iff (!rst_n)
    (evt_valid && !evt_ready) |=> (evt_valid && $stable(evt_ts) && $stable(evt_prev) &&
                                   $stable(evt_curr) && $stable(evt_rose) && $stable(evt_fell)))
    else chk("hold_stable", 32'd0, 32'd1);

  // Reference model: a queue of change records plus the sampling history.
  typedef struct {
    bit [15:0] ts;
    bit [7:0]  prev;
    bit [7:0]  curr;
  } rec_t;

  rec_t      q[$];
  bit [7:0]  m_samp;
  bit        m_primed;
  bit [15:0] m_ts;
  bit        m_ovf;
  int        m_drop;

  task automatic model_update();
    bit   popped;
    rec_t r;
    if (!rst_n) begin
      q.delete();
      m_samp = 0; m_primed = 0; m_ts = 0; m_ovf = 0; m_drop = 0;
      return;
    end
    popped = (q.size() > 0) && evt_ready;
    if (clear_ovf) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    if (popped) void'(q.pop_front());
    if (en) begin
      if (m_primed && sig_in != m_samp) begin
        if (q.size() >= 4) begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end else begin
          r.ts = m_ts; r.prev = m_samp; r.curr = sig_in;
          q.push_back(r);
        end
      end
      m_samp   = sig_in;
      m_primed = 1;
    end
    m_ts = m_ts + 16'd1;
  endtask

  task automatic check_all();
    chk("valid", evt_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    if (q.size() != 0) begin
      chk("ts", evt_ts, q[0].ts);
      chk("prev", evt_prev, q[0].prev);
      chk("curr", evt_curr, q[0].curr);
      chk("rose", evt_rose, q[0].curr & ~q[0].prev);
      chk("fell", evt_fell, ~q[0].curr & q[0].prev);
    end else begin
      chk("ts_idle", evt_ts, 0);
      chk("prev_idle", evt_prev, 0);
      chk("curr_idle", evt_curr, 0);
      chk("rose_idle", evt_rose, 0);
      chk("fell_idle", evt_fell, 0);
    end
  endtask

  // Inputs are set at the falling edge before calling this.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sig_in = 8'h00; clear_ovf = 1'b0; evt_ready = 1'b0;
    @(negedge clk);
    do_reset();
    do_reset();

    // Priming only: a constant bus after reset yields no records.
    en = 1'b1; sig_in = 8'h00;
    repeat (5) cycle();
    chk("t1_level", level, 0);

    // Single change 0F -> F0.
    do_reset();
    sig_in = 8'h0F; evt_ready = 1'b1;
    cycle();
    sig_in = 8'hF0;
    cycle();
    chk("t2_valid", evt_valid, 1);
    chk("t2_prev", evt_prev, 8'h0F);
    chk("t2_curr", evt_curr, 8'hF0);
    chk("t2_rose", evt_rose, 8'hF0);
    chk("t2_fell", evt_fell, 8'h0F);
    chk("t2_ts", evt_ts, 16'd1);
    cycle();

    // Toggle bit0 with the consumer stalled: fill, then overflow and drops.
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sig_in[0] = ~sig_in[0];
      cycle();
    end
    chk("t3_level", level, 4);
    chk("t3_drop", drop_cnt, 4);
    evt_ready = 1'b1;
    repeat (5) cycle();

    // Full FIFO: a change alongside a pop is accepted; clear with a drop counts one.
    evt_ready = 1'b0; clear_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sig_in[1] = ~sig_in[1];
      cycle();
    end
    evt_ready = 1'b1; sig_in[1] = ~sig_in[1];
    cycle();
    chk("t4_level", level, 4);
    evt_ready = 1'b0; clear_ovf = 1'b1; sig_in[1] = ~sig_in[1];
    cycle();
    chk("t4_drop", drop_cnt, 1);
    chk("t4_ovf", overflow, 1);
    clear_ovf = 1'b1; sig_in[1] = ~sig_in[1];
    cycle();
    clear_ovf = 1'b1;
    cycle();
    clear_ovf = 1'b0;
    chk("t4_clear", drop_cnt, 0);
    evt_ready = 1'b1;
    repeat (5) cycle();

    // A change across an en=0 gap is reported against the last enabled sample.
    sig_in = 8'h00;
    cycle();
    cycle();
    en = 1'b0;
    sig_in = 8'h55; cycle();
    sig_in = 8'h00; cycle();
    sig_in = 8'h55; cycle();
    en = 1'b1; evt_ready = 1'b0; sig_in = 8'hAA;
    cycle();
    chk("t5_level", level, 1);
    chk("t5_prev", evt_prev, 8'h00);
    chk("t5_curr", evt_curr, 8'hAA);
    evt_ready = 1'b1;
    cycle();

    // Reset mid-operation discards queued records.
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sig_in = sig_in + 8'd1;
      cycle();
    end
    chk("t6_level_pre", level, 3);
    do_reset();
    chk("t6_valid", evt_valid, 0);
    chk("t6_level", level, 0);
    sig_in = 8'h12; cycle();
    sig_in = 8'h34; cycle();
    chk("t6_prev", evt_prev, 8'h12);
    evt_ready = 1'b1;
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      en        = ($urandom_range(0, 9) < 8);
      sig_in    = ($urandom_range(0, 3) == 0) ? sig_in : 8'($urandom_range(0, 255));
      evt_ready = ($urandom_range(0, 2) == 0);
      clear_ovf = ($urandom_range(0, 29) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    chk("timeout", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "simulation time limit reached");
  end

endmodule
